congestion_estimator: RTL and testbench

Upstream front-end of `traffic_controller`. It accepts per-frame vehicle counts from the ML detector over a valid/ready handshake and averages them over a sliding window. It classifies the average into the 2-bit `congestion_level` with hysteresis. A frame-arrival watchdog raises `fail_safe_en` when the detector stops delivering frames.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/frame_watchdog.sv | 49 ++++
 rtl/congestion_estimator.sv | 115 +++++++++++
 tb/tb_congestion_estimator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings between congestion_estimator and traffic_controller.
// Level encodings are part of the interface to traffic_controller; keep them stable.
package traffic_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'd0,
        LVL_MED  = 2'd1,
        LVL_HIGH = 2'd2,
        LVL_JAM  = 2'd3
    } level_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_CLASSIFY = 2'd2
    } est_state_t;

    function automatic level_t classify(input int unsigned avg,
                                        input int unsigned th_med,
                                        input int unsigned th_high,
                                        input int unsigned th_jam);
        if (avg >= th_jam)  return LVL_JAM;
        if (avg >= th_high) return LVL_HIGH;
        if (avg >= th_med)  return LVL_MED;
        return LVL_LOW;
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Frame-arrival watchdog: raises a sticky fail-safe after TIMEOUT_CYCLES idle edges
// and drops it after RECOVER_FRAMES accepted frames with no further timeout.
module frame_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned RECOVER_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    output logic fail_safe_en
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned REC_W  = $clog2(RECOVER_FRAMES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic [REC_W-1:0]  rec_cnt;
    logic              timeout_hit;

    // Acceptance on the timeout edge clears the counter, so it never "reaches" the limit.
    assign timeout_hit = !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt     <= '0;
            rec_cnt      <= '0;
            fail_safe_en <= 1'b0;
        end else begin
            if (accept) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (timeout_hit) begin
                fail_safe_en <= 1'b1;
                rec_cnt      <= '0;
            end else if (fail_safe_en && accept) begin
                if (rec_cnt == REC_W'(RECOVER_FRAMES - 1)) begin
                    fail_safe_en <= 1'b0;
                    rec_cnt      <= '0;
                end else begin
                    rec_cnt <= rec_cnt + REC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/congestion_estimator.sv
// Sliding-window average of detector vehicle counts, classified into a congestion
// level with downward hysteresis, plus a frame-arrival fail-safe watchdog.
module congestion_estimator
    import traffic_pkg::*;
#(
    parameter int unsigned COUNT_W        = 8,
    parameter int unsigned AVG_DEPTH      = 4,
    parameter int unsigned TH_MED         = 10,
    parameter int unsigned TH_HIGH        = 25,
    parameter int unsigned TH_JAM         = 45,
    parameter int unsigned HYST           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned RECOVER_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count_valid,
    output logic               count_ready,
    input  logic [COUNT_W-1:0] vehicle_count,
    output logic [COUNT_W-1:0] avg_count,
    output logic [1:0]         congestion_level,
    output logic               level_valid,
    output logic               fail_safe_en
);

    localparam int unsigned PTR_W = $clog2(AVG_DEPTH);
    localparam int unsigned SUM_W = COUNT_W + PTR_W;
    localparam int unsigned EXT_W = COUNT_W + 1;

    est_state_t         state;
    logic [COUNT_W-1:0] ring [AVG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [COUNT_W-1:0] pending;
    level_t             level;
    logic               accept;

    logic [EXT_W-1:0]   hyst_ext;
    logic [COUNT_W-1:0] hyst_avg;
    level_t             raw_lvl;
    level_t             hyst_lvl;
    level_t             next_lvl;

    assign count_ready      = (state == ST_IDLE) && !rst;
    assign accept           = count_valid && count_ready;
    assign congestion_level = level;

    // wr_ptr always points at the oldest entry, which the new count replaces.
    always_comb begin
        sum_next = sum + SUM_W'(pending) - SUM_W'(ring[wr_ptr]);
    end

    // A downward move is only taken once avg+HYST also classifies below the current level.
    always_comb begin
        hyst_ext = {1'b0, avg_count} + EXT_W'(HYST);
        hyst_avg = hyst_ext[COUNT_W] ? '1 : hyst_ext[COUNT_W-1:0];
        raw_lvl  = classify(32'(avg_count), TH_MED, TH_HIGH, TH_JAM);
        hyst_lvl = classify(32'(hyst_avg), TH_MED, TH_HIGH, TH_JAM);
        if (raw_lvl >= level) begin
            next_lvl = raw_lvl;
        end else begin
            next_lvl = (hyst_lvl < level) ? hyst_lvl : level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            for (int unsigned i = 0; i < AVG_DEPTH; i++) begin
                ring[i] <= '0;
            end
            wr_ptr      <= '0;
            sum         <= '0;
            pending     <= '0;
            avg_count   <= '0;
            level       <= LVL_LOW;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pending <= vehicle_count;
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    ring[wr_ptr] <= pending;
                    wr_ptr       <= wr_ptr + PTR_W'(1);
                    sum          <= sum_next;
                    avg_count    <= COUNT_W'(sum_next >> PTR_W);
                    state        <= ST_CLASSIFY;
                end
                ST_CLASSIFY: begin
                    level       <= next_lvl;
                    level_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .fail_safe_en(fail_safe_en)
    );

endmodule

// File: tb/tb_congestion_estimator.sv
// Scoreboard bench for congestion_estimator: the driver pushes reference-model results,
// a negedge monitor pops and compares them on every level_valid pulse.
module tb_congestion_estimator;

    logic       clk;
    logic       rst;
    logic       count_valid;
    logic       count_ready;
    logic [7:0] vehicle_count;
    logic [7:0] avg_count;
    logic [1:0] congestion_level;
    logic       level_valid;
    logic       fail_safe_en;

    congestion_estimator #(
        .TIMEOUT_CYCLES(100),
        .RECOVER_FRAMES(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .count_valid     (count_valid),
        .count_ready     (count_ready),
        .vehicle_count   (vehicle_count),
        .avg_count       (avg_count),
        .congestion_level(congestion_level),
        .level_valid     (level_valid),
        .fail_safe_en    (fail_safe_en)
    );

    typedef struct {
        int avg;
        int lvl;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   win[$];
    int   cur_lvl;
    int   cyc;
    int   rel;
    int   compared;
    int   mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cls(input int a);
        if (a >= 45) return 3;
        if (a >= 25) return 2;
        if (a >= 10) return 1;
        return 0;
    endfunction

    // Reference: window average over the last four frames, hysteresis on the way down.
    task automatic model_accept(input int c, input int acc_cyc);
        int s;
        int avg;
        int raw;
        int h;
        exp_t e;
        void'(win.pop_front());
        win.push_back(c);
        s = 0;
        foreach (win[i]) s += win[i];
        avg = s / 4;
        raw = cls(avg);
        if (raw >= cur_lvl) begin
            cur_lvl = raw;
        end else begin
            h = (avg + 2 > 255) ? 255 : avg + 2;
            if (cls(h) < cur_lvl) cur_lvl = cls(h);
        end
        e.avg = avg;
        e.lvl = cur_lvl;
        e.cyc = acc_cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        win = '{0, 0, 0, 0};
        cur_lvl = 0;
    endtask

    // Asserts rst immediately, holds it n edges, checks reset values, releases on a negedge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        count_valid = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_avg", int'(avg_count), 0);
        chk("rst_level", int'(congestion_level), 0);
        chk("rst_level_valid", int'(level_valid), 0);
        chk("rst_fail_safe", int'(fail_safe_en), 0);
        chk("rst_ready", int'(count_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(count_ready), 1);
        rel = cyc;
    endtask

    task automatic send(input int c, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        count_valid = 1'b1;
        vehicle_count = 8'(c);
        while (!count_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!count_ready) begin
            chk("ready_timeout", 0, 1);
            count_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            #1;
            count_valid = 1'b0;
            acc_cyc = cyc;
            model_accept(c, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && level_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_level_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_avg", int'(avg_count), e.avg);
                chk("sb_level", int'(congestion_level), e.lvl);
                chk("sb_pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

    initial begin
        int t;
        int ramp_avg[4];
        int n_acc;
        int last;
        bit hit;

        ramp_avg = '{3, 6, 9, 12};
        compared = 0;
        mismatched = 0;
        cyc = 0;
        rst = 1'b1;
        count_valid = 1'b0;
        vehicle_count = '0;

        do_reset(5);

        // Ramp-up with explicit avg at T+1
        for (int i = 0; i < 4; i++) begin
            send(12, t);
            @(posedge clk);
            #1;
            chk("ramp_avg_t1", int'(avg_count), ramp_avg[i]);
        end
        // Hysteresis: avg 11, then 9, 9, then 7
        send(8, t);
        send(4, t);
        send(12, t);
        send(4, t);
        repeat (4) @(posedge clk);
        #1;
        chk("hyst_final_level", int'(congestion_level), 0);

        // Jump directly to JAM
        @(negedge clk);
        do_reset(2);
        send(200, t);
        repeat (4) @(posedge clk);
        #1;
        chk("jump_level", int'(congestion_level), 3);

        // Backpressure: valid held for 10 edges
        @(negedge clk);
        count_valid = 1'b1;
        vehicle_count = 8'd30;
        n_acc = 0;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            hit = count_ready;
            @(posedge clk);
            #1;
            if (hit) begin
                n_acc++;
                model_accept(30, cyc);
                if (n_acc > 1) chk("bp_spacing", cyc - last, 3);
                last = cyc;
            end
            if (i < 9) @(negedge clk);
        end
        count_valid = 1'b0;
        chk("bp_accept_count", n_acc, 4);
        repeat (4) @(posedge clk);

        // Watchdog: timeout from reset
        @(negedge clk);
        do_reset(2);
        repeat (99) @(posedge clk);
        #1;
        chk("wd_before_timeout", int'(fail_safe_en), 0);
        @(posedge clk);
        #1;
        chk("wd_at_timeout", int'(fail_safe_en), 1);
        chk("wd_edge_index", cyc - rel, 100);

        // Watchdog: timeout after a frame, then two-frame recovery
        @(negedge clk);
        do_reset(2);
        send(5, t);
        repeat (99) @(posedge clk);
        #1;
        chk("wd2_before_timeout", int'(fail_safe_en), 0);
        @(posedge clk);
        #1;
        chk("wd2_at_timeout", int'(fail_safe_en), 1);
        send(7, t);
        chk("wd2_after_first_recover", int'(fail_safe_en), 1);
        send(9, t);
        chk("wd2_after_second_recover", int'(fail_safe_en), 0);
        repeat (4) @(posedge clk);

        // Watchdog: acceptance on edge 100 wins
        @(negedge clk);
        do_reset(2);
        repeat (99) @(posedge clk);
        #1;
        send(3, t);
        chk("wd3_accept_edge", t - rel, 100);
        chk("wd3_no_fail_safe", int'(fail_safe_en), 0);
        repeat (4) @(posedge clk);

        // Mid-ACCUM reset discards the in-flight count
        @(negedge clk);
        do_reset(2);
        send(60, t);
        do_reset(2);
        chk("midrst_avg", int'(avg_count), 0);
        chk("midrst_level", int'(congestion_level), 0);
        send(4, t);
        @(posedge clk);
        #1;
        chk("midrst_next_avg", int'(avg_count), 1);
        repeat (4) @(posedge clk);

        // Randomized traffic
        @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            int c;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            if ($urandom_range(0, 3) == 0) c = int'($urandom_range(0, 255));
            else c = int'($urandom_range(0, 60));
            send(c, t);
            if (i % 50 == 49) chk("rand_no_fail_safe", int'(fail_safe_en), 0);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
